regfile_ab: RTL

REGFILE_AB -- requirements
Module: regfile_ab

---
 rtl/regfile_ab.sv | 76 +++++++
 1 files changed

// File: rtl/regfile_ab.sv
// 31-entry register file (r0 hard-wired to zero) with two combinational read ports,
// registered operand latches A/B and a sticky multi-hot write-enable error flag.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_ab #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       WriteEn,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [4:0]        ReadRegister1,
   input  logic [4:0]        ReadRegister2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              WeErr
);

   logic [DATA_W-1:0] regs_q [1:31];
   logic [DATA_W-1:0] regs_d [1:31];
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] rd1, rd2;
   logic              we_err_q, we_err_d;
   logic              we_multi;

   // Clearing the lowest set bit leaves something only when two or more bits were set.
   assign we_multi = (WriteEn & (WriteEn - 32'd1)) != 32'd0;

   always_comb begin
      regs_d   = regs_q;
      we_err_d = we_err_q | we_multi;
      if (!we_multi) begin
         for (int unsigned i = 1; i < 32; i++) begin
            if (WriteEn[i]) regs_d[i] = WriteData;
         end
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      for (int unsigned i = 1; i < 32; i++) begin
         if (ReadRegister1 == 5'(i)) rd1 = regs_q[i];
         if (ReadRegister2 == 5'(i)) rd2 = regs_q[i];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward only a legal single-hot write to a real register outside reset.
      if (!reset && !we_multi) begin
         if (ReadRegister1 != 5'd0 && WriteEn[ReadRegister1]) rd1 = WriteData;
         if (ReadRegister2 != 5'd0 && WriteEn[ReadRegister2]) rd2 = WriteData;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 1; i < 32; i++) regs_q[i] <= '0;
         a_q      <= '0;
         b_q      <= '0;
         we_err_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         a_q      <= rd1;
         b_q      <= rd2;
         we_err_q <= we_err_d;
      end
   end

   assign ReadData1 = rd1;
   assign ReadData2 = rd2;
   assign A         = a_q;
   assign B         = b_q;
   assign WeErr     = we_err_q;

endmodule
